energy_sweep_ctrl: RTL

Sequencer for partial_energy_calc that computes the total Ising energy of a spin configuration. On start it latches the spin vector and issues DATASPIN weight/bias row fetches, one per spin index. It drives the datapath's data_valid and current_spin in step with the returned rows, tracks the PIPES-deep datapath latency and accumulates energy_o. It presents the total on a valid/ready result port. It sits between the energy-monitor top, the weight memory and one partial_energy_calc instance.

---
 rtl/energy_monitor_pkg.sv | 15 +
 rtl/valid_delay_line.sv | 44 ++++
 rtl/energy_sweep_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/energy_monitor_pkg.sv
// rtl/energy_monitor_pkg.sv - shared types and helpers for the energy sweep sequencer
package energy_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

  function automatic int total_energy_bits(input int local_bits, input int rows);
    return local_bits + $clog2(rows);
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - PIPES-deep valid shift register with synchronous clear
module valid_delay_line #(
  parameter int PIPES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic valid_i,
  output logic valid_o,
  output logic empty_o
);

  if (PIPES == 0) begin : g_pass
    // No storage: the datapath result lines up with the response itself.
    logic unused_pass;
    assign unused_pass = clk_i ^ rst_i ^ clr_i;
    assign valid_o     = valid_i;
    assign empty_o     = 1'b1;
  end else begin : g_pipe
    logic [PIPES-1:0] sr_q, sr_d;

    always_comb begin
      sr_d = '0;
      if (!clr_i) begin
        sr_d[0] = valid_i;
        for (int i = 1; i < PIPES; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign valid_o = sr_q[PIPES-1];
    assign empty_o = ~|sr_q;
  end

endmodule

// File: rtl/energy_sweep_ctrl.sv
// rtl/energy_sweep_ctrl.sv - sequences row fetches into partial_energy_calc and accumulates the total energy
module energy_sweep_ctrl
  import energy_monitor_pkg::*;
#(
  parameter int DATASPIN         = 256,
  parameter int PIPES            = 0,
  parameter int LOCAL_ENERGY_BIT = 16,
  parameter int TOTAL_ENERGY_BIT = total_energy_bits(LOCAL_ENERGY_BIT, DATASPIN),
  parameter int IDXW             = $clog2(DATASPIN)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               en_i,
  input  logic                               start_i,
  input  logic [DATASPIN-1:0]                spin_vector_i,
  output logic                               busy_o,
  output logic                               abort_o,
  output logic                               req_valid_o,
  input  logic                               req_ready_i,
  output logic [IDXW-1:0]                    req_addr_o,
  input  logic                               rsp_valid_i,
  output logic                               pe_en_o,
  output logic                               pe_data_valid_o,
  output logic [DATASPIN-1:0]                pe_spin_vector_o,
  output logic                               pe_current_spin_o,
  input  logic signed [LOCAL_ENERGY_BIT-1:0] pe_energy_i,
  output logic signed [TOTAL_ENERGY_BIT-1:0] energy_o,
  output logic                               energy_valid_o,
  input  logic                               energy_ready_i
);

  // Counters carry one extra bit so that the value DATASPIN is representable.
  localparam logic [IDXW:0] NROWS    = (IDXW + 1)'(DATASPIN);
  localparam logic [IDXW:0] LAST_ROW = (IDXW + 1)'(DATASPIN - 1);
  localparam logic [IDXW:0] IDX_ONE  = (IDXW + 1)'(1);

  state_e                               state_q, state_d;
  logic [DATASPIN-1:0]                  spin_q, spin_d;
  logic [IDXW:0]                        req_idx_q, req_idx_d;
  logic [IDXW:0]                        rsp_idx_q, rsp_idx_d;
  logic signed [TOTAL_ENERGY_BIT-1:0]   acc_q, acc_d;

  logic req_fire;
  logic rsp_fire;
  logic abort;
  logic dl_valid;
  logic dl_empty;

  always_comb begin
    req_valid_o = (state_q == SWEEP) && (req_idx_q < NROWS);
    req_fire    = req_valid_o && req_ready_i;
    rsp_fire    = (state_q == SWEEP) && rsp_valid_i;
    abort       = ((state_q == SWEEP) || (state_q == DRAIN)) && !en_i;
  end

  valid_delay_line #(
    .PIPES(PIPES)
  ) u_valid_delay_line (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (abort),
    .valid_i(rsp_fire),
    .valid_o(dl_valid),
    .empty_o(dl_empty)
  );

  always_comb begin
    state_d   = state_q;
    spin_d    = spin_q;
    req_idx_d = req_idx_q;
    rsp_idx_d = rsp_idx_q;
    acc_d     = acc_q;

    if (dl_valid && !abort) begin
      acc_d = acc_q + {{(TOTAL_ENERGY_BIT - LOCAL_ENERGY_BIT){pe_energy_i[LOCAL_ENERGY_BIT-1]}},
                       pe_energy_i};
    end

    case (state_q)
      IDLE: begin
        if (start_i && en_i) begin
          spin_d    = spin_vector_i;
          req_idx_d = '0;
          rsp_idx_d = '0;
          acc_d     = '0;
          state_d   = SWEEP;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (req_fire) begin
            req_idx_d = req_idx_q + IDX_ONE;
          end
          if (rsp_fire) begin
            rsp_idx_d = rsp_idx_q + IDX_ONE;
            if (rsp_idx_q == LAST_ROW) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (dl_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (energy_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      spin_q    <= '0;
      req_idx_q <= '0;
      rsp_idx_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      spin_q    <= spin_d;
      req_idx_q <= req_idx_d;
      rsp_idx_q <= rsp_idx_d;
      acc_q     <= acc_d;
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign abort_o           = abort;
  assign req_addr_o        = req_idx_q[IDXW-1:0];
  assign pe_en_o           = en_i;
  assign pe_data_valid_o   = rsp_fire;
  assign pe_spin_vector_o  = spin_q;
  assign pe_current_spin_o = spin_q[rsp_idx_q[IDXW-1:0]];
  assign energy_o          = acc_q;
  assign energy_valid_o    = (state_q == DONE);

endmodule
